// File: rtl/edge_event_logger.sv
// Edge event logger: stores nonzero edge vectors with a free-running timestamp
// in a small FIFO and hands them to a reader over valid/ready.
module edge_event_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 edge_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_edges,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    input  logic                       clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [TS_W-1:0] r_ts;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;
    logic [7:0]      r_mem_edges [DEPTH];
    logic [TS_W-1:0] r_mem_ts    [DEPTH];

    logic w_event;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_event = |edge_in;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage carries no reset; stale contents are masked by the gated outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_edges[r_wr_ptr] <= edge_in;
            r_mem_ts[r_wr_ptr]    <= r_ts;
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_overflow) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign out_valid = !w_empty;
    assign out_edges = w_empty ? 8'h00 : r_mem_edges[r_rd_ptr];
    assign out_ts    = w_empty ? '0 : r_mem_ts[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
